wb_result_mux: RTL and testbench
================================

Name: wb_result_mux

Overview:
- Writeback-side counterpart of the ALU operand select path: takes the retiring instruction's result sources and returns one value to the register file write port.
- Sources are ALU result, load data, PC+4 and immediate (LUI).
- Load results arrive from data memory with variable latency. A small FSM holds the instruction until the data arrives, then sign- or zero-extends it.
- All register-file write outputs are registered.

Parameters:
XLEN, 32, datapath width.
WB_ALU/WB_MEM/WB_PC4/WB_IMM, 2'd0/2'd1/2'd2/2'd3, wb_sel encodings.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  retiring instruction presented.
in_ready  output  1  block can accept an instruction.
wb_sel  input  2  result source select.
reg_write  input  1  instruction writes rd.
rd  input  5  destination register.
funct3  input  3  load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
alu_result  input  XLEN  ALU output; for loads, the byte address.
pc  input  XLEN  instruction PC.
immediate  input  XLEN  from imm generator.
mem_rvalid  input  1  load data valid.
mem_rdata  input  XLEN  raw word from data memory.
rf_we  output  1  register file write enable.
rf_waddr  output  5  register file write address.
rf_wdata  output  XLEN  register file write data.
busy  output  1  load outstanding (stall request to fetch).

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset: state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, busy=0. in_ready=1 once reset is released.
- Reset asserted mid-load drops the pending load. No write occurs. A mem_rvalid arriving after reset release is ignored.
- States:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0, busy=1.
- Transfer occurs when in_valid & in_ready.
- Non-load transfer (wb_sel != WB_MEM):
  - Next cycle: rf_we=reg_write & (rd!=0), rf_waddr=rd.
  - rf_wdata is alu_result, pc+4 (mod 2^XLEN, wraps at 0xFFFFFFFC→0) or immediate, per wb_sel.
  - State stays IDLE. Back-to-back transfers are allowed every cycle.
- Load transfer (wb_sel == WB_MEM):
  - Latch rd, reg_write, funct3 and alu_result[1:0]. Go to WAIT_MEM.
  - rf_we=0 on the next cycle.
- WAIT_MEM:
  - On mem_rvalid, next cycle: rf_we=reg_write_latched & (rd!=0), rf_wdata=extended data. Return to IDLE.
  - in_ready returns to 1 in the cycle after mem_rvalid.
  - Minimum load latency: issue at cycle N, mem_rvalid at N+1, write at N+2.
- Extraction:
  - Byte lane = addr[1:0], bits [8*addr+7 : 8*addr].
  - Halfword lane = addr[1]; addr[0] is ignored.
  - Word ignores addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 (011, 110, 111) is treated as LW.
- mem_rvalid while IDLE, including the same cycle as a load transfer, is ignored.
- rf_we is a single-cycle pulse per instruction. rf_waddr/rf_wdata hold their last value when rf_we=0.
- rd=0 never produces rf_we=1, regardless of reg_write.

Decomposition:
- Shared package: XLEN, the WB_* select encodings, funct3 load codes, FSM state enum.
- One sub-module, load_extend: combinational lane select plus sign/zero extend of (mem_rdata, addr[1:0], funct3). Instantiated once in the WAIT_MEM data path.

Test Plan:
- ALU path: wb_sel=0, rd=5, alu_result=0x1234_5678, reg_write=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678; in_ready stays 1.
- PC+4 wrap and x0: wb_sel=2, pc=0xFFFF_FFFC, rd=1 → rf_wdata=0x0000_0000. Repeat with rd=0 → rf_we=0.
- LB sign-extend: load funct3=000, addr=...3, mem_rvalid 3 cycles later with mem_rdata=0x80FF_0011 → busy=1 for 3 cycles, then rf_wdata=0xFFFF_FF80, rf_we one cycle.
- LHU: funct3=101, addr=...2, mem_rdata=0xBEEF_1234 → rf_wdata=0x0000_BEEF. Back-to-back non-load in the cycle after mem_rvalid → accepted; writes land on consecutive cycles.
- Spurious and same-cycle mem_rvalid: mem_rvalid=1 in IDLE, and in the load issue cycle → no rf_we. Load still waits for a later mem_rvalid.
- Reset mid-load: assert rst_n=0 in WAIT_MEM → rf_we=0 and busy=0 immediately. After release, mem_rvalid=1 → no write; in_ready=1.

Source files
------------

// File: rtl/wb_result_mux_pkg.sv
// rtl/wb_result_mux_pkg.sv - shared widths, select encodings, load codes and FSM states
package wb_result_mux_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE,
    S_WAIT_MEM
  } wb_state_e;

endpackage

// File: rtl/wb_result_mux_load_extend.sv
// rtl/wb_result_mux_load_extend.sv - load lane select plus sign/zero extension
module load_extend
  import wb_result_mux_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (addr_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    // addr[0] is deliberately ignored for halfwords
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_result_mux.sv
// rtl/wb_result_mux.sv - writeback result select with variable-latency load wait
module wb_result_mux
  import wb_result_mux_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      wb_sel,
  input  logic            reg_write,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] immediate,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy
);

  wb_state_e       state_q, state_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            ld_we_q, ld_we_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_addr_q, ld_addr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] src_data;

  load_extend u_load_extend (
    .rdata_i  (mem_rdata),
    .addr_i   (ld_addr_q),
    .funct3_i (ld_f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    src_data = alu_result;
    case (wb_sel)
      WB_PC4:  src_data = pc + XLEN'(4);
      WB_IMM:  src_data = immediate;
      default: src_data = alu_result;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    ld_f3_d    = ld_f3_q;
    ld_addr_d  = ld_addr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (wb_sel == WB_MEM) begin
            ld_rd_d   = rd;
            ld_we_d   = reg_write && (rd != 5'd0);
            ld_f3_d   = funct3;
            ld_addr_d = alu_result[1:0];
            state_d   = S_WAIT_MEM;
          end else if (reg_write && (rd != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            rf_wdata_d = src_data;
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          if (ld_we_q) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = ld_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset drops any pending load, so a late mem_rvalid finds the FSM in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_f3_q    <= '0;
      ld_addr_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      ld_f3_q    <= ld_f3_d;
      ld_addr_q  <= ld_addr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_WAIT_MEM);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_result_mux.sv
// tb/tb_wb_result_mux.sv - scoreboard bench for wb_result_mux
module tb_wb_result_mux;
  import wb_result_mux_pkg::*;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] immediate;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   wr_cyc_q[$];
  exp_t mon_e;

  wb_result_mux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wb_sel     (wb_sel),
    .reg_write  (reg_write),
    .rd         (rd),
    .funct3     (funct3),
    .alu_result (alu_result),
    .pc         (pc),
    .immediate  (immediate),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every observed write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got waddr=%0d wdata=%h expected no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_waddr !== mon_e.waddr || rf_wdata !== mon_e.wdata) begin
          failures++;
          $display("FAIL wb_write got waddr=%0d wdata=%h expected waddr=%0d wdata=%h",
                   rf_waddr, rf_wdata, mon_e.waddr, mon_e.wdata);
        end
      end
    end
  end

  task automatic drive_instr(input logic [1:0] sel, input logic rw, input logic [4:0] r,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] p, input logic [31:0] imm);
    in_valid = 1'b1; wb_sel = sel; reg_write = rw; rd = r; funct3 = f3;
    alu_result = alu; pc = p; immediate = imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic mem_resp(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_cycles(2);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL alu_ready_pre got=%b exp=1", in_ready); end
    exp_q.push_back(exp_t'{5'd5, 32'h1234_5678});
    drive_instr(WB_ALU, 1'b1, 5'd5, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alu_we got=%b exp=1", rf_we); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL alu_ready_post got=%b exp=1", in_ready); end
    idle_cycles(1);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL alu_we_pulse got=%b exp=0", rf_we); end
    checks++;
    if (rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
      failures++; $display("FAIL alu_hold got waddr=%0d wdata=%h exp waddr=5 wdata=12345678", rf_waddr, rf_wdata);
    end
    idle_cycles(1);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL alu_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_pc4_x0;
    exp_q.push_back(exp_t'{5'd1, 32'h0});
    drive_instr(WB_PC4, 1'b1, 5'd1, 3'd0, 32'hDEAD_0000, 32'hFFFF_FFFC, 32'h0);
    checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL pc4_wrap got=%h exp=00000000", rf_wdata); end
    drive_instr(WB_PC4, 1'b1, 5'd0, 3'd0, 32'h0, 32'h0000_0100, 32'h0);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_we got=%b exp=0", rf_we); end
    drive_instr(WB_ALU, 1'b0, 5'd3, 3'd0, 32'h5555_5555, 32'h0, 32'h0);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL noregwrite_we got=%b exp=0", rf_we); end
    exp_q.push_back(exp_t'{5'd7, 32'hABCD_E000});
    drive_instr(WB_IMM, 1'b1, 5'd7, 3'd0, 32'h1, 32'h2, 32'hABCD_E000);
    checks++; if (rf_wdata !== 32'hABCD_E000) begin failures++; $display("FAIL imm_data got=%h exp=abcde000", rf_wdata); end
    idle_cycles(2);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pc4_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_lb;
    exp_q.push_back(exp_t'{5'd9, 32'hFFFF_FF80});
    drive_instr(WB_MEM, 1'b1, 5'd9, F3_LB, 32'h0000_1003, 32'h0, 32'h0);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL lb_issue_we got=%b exp=0", rf_we); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL lb_wait%0d got busy=%b in_ready=%b exp busy=1 in_ready=0", i, busy, in_ready);
      end
      if (i == 2) mem_resp(32'h80FF_0011);
      else idle_cycles(1);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lb_busy_done got=%b exp=0", busy); end
    checks++; if (rf_wdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", rf_wdata); end
    idle_cycles(1);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL lb_we_pulse got=%b exp=0", rf_we); end
    idle_cycles(1);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lb_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_lhu_back_to_back;
    wr_cyc_q.delete();
    exp_q.push_back(exp_t'{5'd10, 32'h0000_BEEF});
    drive_instr(WB_MEM, 1'b1, 5'd10, F3_LHU, 32'h0000_2002, 32'h0, 32'h0);
    mem_resp(32'hBEEF_1234);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lhu_ready got=%b exp=1", in_ready); end
    exp_q.push_back(exp_t'{5'd11, 32'h0000_0055});
    drive_instr(WB_ALU, 1'b1, 5'd11, 3'd0, 32'h0000_0055, 32'h0, 32'h0);
    idle_cycles(2);
    checks++;
    if (wr_cyc_q.size() != 2) begin
      failures++; $display("FAIL b2b_count got=%0d exp=2", wr_cyc_q.size());
    end else if (wr_cyc_q[1] - wr_cyc_q[0] != 1) begin
      failures++; $display("FAIL b2b_spacing got=%0d exp=1", wr_cyc_q[1] - wr_cyc_q[0]);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_extract;
    logic [2:0]  t_f3   [0:10];
    logic [31:0] t_addr [0:10];
    logic [31:0] t_data [0:10];
    logic [31:0] t_exp  [0:10];
    t_f3   = '{F3_LH, F3_LH, F3_LBU, F3_LB, F3_LW, 3'b011, 3'b110, 3'b111, F3_LB, F3_LHU, F3_LBU};
    t_addr = '{32'h1001, 32'h1003, 32'h1002, 32'h1001, 32'h1003, 32'h1001, 32'h1002, 32'h1000,
               32'h1000, 32'h1000, 32'h1003};
    t_data = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h00AB_0000, 32'h0000_7F00, 32'hDEAD_BEEF, 32'hCAFE_F00D,
               32'h8000_0080, 32'h1234_5680, 32'h1234_5680, 32'h0000_8001, 32'hF000_0000};
    t_exp  = '{32'h0000_7FFF, 32'hFFFF_8001, 32'h0000_00AB, 32'h0000_007F, 32'hDEAD_BEEF, 32'hCAFE_F00D,
               32'h8000_0080, 32'h1234_5680, 32'hFFFF_FF80, 32'h0000_8001, 32'h0000_00F0};
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(exp_t'{5'(20 + i), t_exp[i]});
      drive_instr(WB_MEM, 1'b1, 5'(20 + i), t_f3[i], t_addr[i], 32'h0, 32'h0);
      mem_resp(t_data[i]);
    end
    drive_instr(WB_MEM, 1'b0, 5'd4, F3_LW, 32'h0, 32'h0, 32'h0);
    mem_resp(32'h1111_2222);
    drive_instr(WB_MEM, 1'b1, 5'd0, F3_LW, 32'h0, 32'h0, 32'h0);
    mem_resp(32'h3333_4444);
    idle_cycles(2);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL extract_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_spurious;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    idle_cycles(1);
    mem_rvalid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_idle_busy got=%b exp=0", busy); end
    exp_q.push_back(exp_t'{5'd12, 32'h0BAD_F00D});
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    drive_instr(WB_MEM, 1'b1, 5'd12, F3_LW, 32'h0, 32'h0, 32'h0);
    mem_rvalid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL spur_issue_busy got=%b exp=1", busy); end
    idle_cycles(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL spur_still_wait got=%b exp=1", busy); end
    mem_resp(32'h0BAD_F00D);
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL spur_load_we got=%b exp=1", rf_we); end
    idle_cycles(2);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL spur_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_load;
    drive_instr(WB_MEM, 1'b1, 5'd13, F3_LW, 32'h0, 32'h0, 32'h0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rml_busy_pre got=%b exp=1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rf_we !== 1'b0) begin
      failures++; $display("FAIL rml_async got busy=%b rf_we=%b exp busy=0 rf_we=0", busy, rf_we);
    end
    idle_cycles(2);
    rst_n = 1'b1;
    mem_resp(32'h7777_7777);
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rml_late_we got=%b exp=0", rf_we); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rml_ready got=%b exp=1", in_ready); end
    idle_cycles(2);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rml_drain got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wb_sel = WB_ALU; reg_write = 1'b0; rd = 5'd0;
    funct3 = 3'd0; alu_result = '0; pc = '0; immediate = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_alu();
    test_pc4_x0();
    test_lb();
    test_lhu_back_to_back();
    test_extract();
    test_spurious();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
